// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin arbiter for one single-port BRAM with bounded burst hold.
// Registers the BRAM command and steers read data back to the issuing requester.
module bram_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int WEN_WIDTH    = (DATA_WIDTH + 7) / 8,
    parameter int READ_LATENCY = 1,
    parameter int MAX_BURST    = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  P0_Req,
    input  logic [ADDR_WIDTH-1:0] P0_Addr,
    input  logic [DATA_WIDTH-1:0] P0_Din,
    input  logic [WEN_WIDTH-1:0]  P0_WEN,
    output logic                  P0_Gnt,
    output logic [DATA_WIDTH-1:0] P0_Dout,
    output logic                  P0_RValid,
    input  logic                  P1_Req,
    input  logic [ADDR_WIDTH-1:0] P1_Addr,
    input  logic [DATA_WIDTH-1:0] P1_Din,
    input  logic [WEN_WIDTH-1:0]  P1_WEN,
    output logic                  P1_Gnt,
    output logic [DATA_WIDTH-1:0] P1_Dout,
    output logic                  P1_RValid,
    output logic [ADDR_WIDTH-1:0] O_Addr,
    output logic                  O_EN,
    output logic [DATA_WIDTH-1:0] O_Din,
    output logic [WEN_WIDTH-1:0]  O_WEN,
    input  logic [DATA_WIDTH-1:0] O_Dout,
    output logic                  Owner,
    output logic                  Busy
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_BURST);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic [CW-1:0]           count_r;
    logic [CW-1:0]           next_count_s;
    logic [CW-1:0]           count_inc_s;
    logic                    last_r;
    logic                    owner_r;
    logic                    gnt0_s;
    logic                    gnt1_s;
    logic                    push_s;
    logic [READ_LATENCY-1:0] tag_v_r;
    logic [READ_LATENCY-1:0] tag_id_r;
    logic                    rv0_r;
    logic                    rv1_r;

    // Grant selection and next-state/count computation
    always_comb begin
        gnt0_s       = 1'b0;
        gnt1_s       = 1'b0;
        next_state_s = IDLE;
        next_count_s = count_r;
        count_inc_s  = (count_r == MAX_C) ? MAX_C : (count_r + ONE_C);
        case (state_r)
            IDLE: begin
                if (P0_Req && P1_Req) begin
                    gnt0_s = last_r;
                    gnt1_s = ~last_r;
                end else if (P0_Req) begin
                    gnt0_s = 1'b1;
                end else if (P1_Req) begin
                    gnt1_s = 1'b1;
                end else begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            end
            OWN0: begin
                if (P0_Req && ((count_r < MAX_C) || !P1_Req)) begin
                    gnt0_s = 1'b1;
                end else if (P1_Req) begin
                    gnt1_s = 1'b1;
                end else begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            end
            OWN1: begin
                if (P1_Req && ((count_r < MAX_C) || !P0_Req)) begin
                    gnt1_s = 1'b1;
                end else if (P0_Req) begin
                    gnt0_s = 1'b1;
                end else begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            end
            default: begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        endcase
        // Staying with the same owner extends the burst; any handover restarts it at 1
        if (gnt0_s) begin
            next_state_s = OWN0;
            next_count_s = (state_r == OWN0) ? count_inc_s : ONE_C;
        end else if (gnt1_s) begin
            next_state_s = OWN1;
            next_count_s = (state_r == OWN1) ? count_inc_s : ONE_C;
        end else begin
            next_state_s = IDLE;
            next_count_s = count_r;
        end
    end

    // Arbitration state, burst counter and round-robin history
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r <= IDLE;
            count_r <= {CW{1'b0}};
            last_r  <= 1'b1;
            owner_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            count_r <= next_count_s;
            if (gnt0_s || gnt1_s) begin
                last_r  <= gnt1_s;
                owner_r <= gnt1_s;
            end else begin
                last_r  <= last_r;
                owner_r <= owner_r;
            end
        end
    end

    // Registered BRAM command; only the enable drops on idle cycles
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            O_EN   <= 1'b0;
            O_Addr <= {ADDR_WIDTH{1'b0}};
            O_Din  <= {DATA_WIDTH{1'b0}};
            O_WEN  <= {WEN_WIDTH{1'b0}};
        end else if (gnt0_s) begin
            O_EN   <= 1'b1;
            O_Addr <= P0_Addr;
            O_Din  <= P0_Din;
            O_WEN  <= P0_WEN;
        end else if (gnt1_s) begin
            O_EN   <= 1'b1;
            O_Addr <= P1_Addr;
            O_Din  <= P1_Din;
            O_WEN  <= P1_WEN;
        end else begin
            O_EN   <= 1'b0;
        end
    end

    assign push_s = (gnt0_s && (P0_WEN == {WEN_WIDTH{1'b0}})) ||
                    (gnt1_s && (P1_WEN == {WEN_WIDTH{1'b0}}));

    // Read-tag pipe aligned with O_EN; the final register lines up with BRAM data
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            tag_v_r  <= {READ_LATENCY{1'b0}};
            tag_id_r <= {READ_LATENCY{1'b0}};
            rv0_r    <= 1'b0;
            rv1_r    <= 1'b0;
        end else begin
            tag_v_r[0]  <= push_s;
            tag_id_r[0] <= gnt1_s;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_v_r[i]  <= tag_v_r[i-1];
                tag_id_r[i] <= tag_id_r[i-1];
            end
            rv0_r <= tag_v_r[READ_LATENCY-1] & ~tag_id_r[READ_LATENCY-1];
            rv1_r <= tag_v_r[READ_LATENCY-1] &  tag_id_r[READ_LATENCY-1];
        end
    end

    assign P0_Gnt    = gnt0_s & ~Rst;
    assign P1_Gnt    = gnt1_s & ~Rst;
    assign P0_RValid = rv0_r;
    assign P1_RValid = rv1_r;
    assign P0_Dout   = rv0_r ? O_Dout : {DATA_WIDTH{1'b0}};
    assign P1_Dout   = rv1_r ? O_Dout : {DATA_WIDTH{1'b0}};
    assign Owner     = owner_r;
    assign Busy      = (state_r != IDLE) || (|tag_v_r);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter (READ_LATENCY=3, MAX_BURST=8): a vector
// table for reads/writes/interleaving plus sequences for bursts, lone requester and reset.
module tb_bram_port_arbiter;

    localparam int RL = 3;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        P0_Req, P1_Req;
    logic [31:0] P0_Addr, P1_Addr, P0_Din, P1_Din;
    logic [3:0]  P0_WEN, P1_WEN;
    logic        P0_Gnt, P1_Gnt, P0_RValid, P1_RValid;
    logic [31:0] P0_Dout, P1_Dout;
    logic [31:0] O_Addr, O_Din;
    logic        O_EN;
    logic [3:0]  O_WEN;
    logic [31:0] bram_dout;
    logic        Owner, Busy;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] cyc      = 16'd0;

    bram_port_arbiter #(.READ_LATENCY(RL), .MAX_BURST(8)) dut (
        .Clk(Clk), .Rst(Rst),
        .P0_Req(P0_Req), .P0_Addr(P0_Addr), .P0_Din(P0_Din), .P0_WEN(P0_WEN),
        .P0_Gnt(P0_Gnt), .P0_Dout(P0_Dout), .P0_RValid(P0_RValid),
        .P1_Req(P1_Req), .P1_Addr(P1_Addr), .P1_Din(P1_Din), .P1_WEN(P1_WEN),
        .P1_Gnt(P1_Gnt), .P1_Dout(P1_Dout), .P1_RValid(P1_RValid),
        .O_Addr(O_Addr), .O_EN(O_EN), .O_Din(O_Din), .O_WEN(O_WEN),
        .O_Dout(bram_dout), .Owner(Owner), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        r0;
        logic [31:0] a0;
        logic [3:0]  w0;
        logic        r1;
        logic [31:0] a1;
        logic [3:0]  w1;
        logic [31:0] d1;
        logic        g0;
        logic        g1;
        logic        en;
        logic [31:0] oaddr;
        logic [3:0]  owen;
        logic [31:0] odin;
        logic        rv0;
        logic        rv1;
        logic        busy;
        logic        owner;
    } vec_t;

    vec_t tbl [20];

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Advance one clock, land 1 time unit after the edge, refresh the BRAM data pattern
    task automatic tick();
        @(posedge Clk);
        #1;
        cyc       = cyc + 16'd1;
        bram_dout = {16'hC0DE, cyc};
    endtask

    task automatic idle_inputs();
        P0_Req = 1'b0; P0_Addr = 32'h0; P0_WEN = 4'h0;
        P1_Req = 1'b0; P1_Addr = 32'h0; P1_WEN = 4'h0; P1_Din = 32'h0;
    endtask

    initial begin
        //           r0    a0          w0    r1    a1          w1    d1             g0    g1    en    oaddr       owen  odin           rv0   rv1   busy  owner
        tbl[0]  = '{1'b0, 32'h0,      4'h0, 1'b0, 32'h0,      4'h0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,      4'h0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 32'h10,     4'h0, 1'b0, 32'h0,      4'h0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,      4'h0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 32'h0,      4'h0, 1'b0, 32'h0,      4'h0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h10,     4'h0, 32'h55,        1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 32'h0,      4'h0, 1'b0, 32'h0,      4'h0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h10,     4'h0, 32'h55,        1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 32'h0,      4'h0, 1'b0, 32'h0,      4'h0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h10,     4'h0, 32'h55,        1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 32'h0,      4'h0, 1'b1, 32'h20,     4'hF, 32'hDEADBEEF,  1'b0, 1'b1, 1'b0, 32'h10,     4'h0, 32'h55,        1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 32'h0,      4'h0, 1'b0, 32'h0,      4'h0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h20,     4'hF, 32'hDEADBEEF,  1'b0, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 32'h0,      4'h0, 1'b0, 32'h0,      4'h0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h20,     4'hF, 32'hDEADBEEF,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = tbl[7];
        tbl[9]  = tbl[7];
        tbl[10] = tbl[7];
        tbl[11] = '{1'b1, 32'h100,    4'h0, 1'b0, 32'h0,      4'h0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h20,     4'hF, 32'hDEADBEEF,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 32'h0,      4'h0, 1'b1, 32'h104,    4'h0, 32'h77,        1'b0, 1'b1, 1'b1, 32'h100,    4'h0, 32'h55,        1'b0, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 32'h108,    4'h0, 1'b0, 32'h0,      4'h0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h104,    4'h0, 32'h77,        1'b0, 1'b0, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 32'h0,      4'h0, 1'b1, 32'h10C,    4'h0, 32'h77,        1'b0, 1'b1, 1'b1, 32'h108,    4'h0, 32'h55,        1'b0, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 32'h0,      4'h0, 1'b0, 32'h0,      4'h0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h10C,    4'h0, 32'h77,        1'b1, 1'b0, 1'b1, 1'b1};
        tbl[16] = '{1'b0, 32'h0,      4'h0, 1'b0, 32'h0,      4'h0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h10C,    4'h0, 32'h77,        1'b0, 1'b1, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 32'h0,      4'h0, 1'b0, 32'h0,      4'h0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h10C,    4'h0, 32'h77,        1'b1, 1'b0, 1'b1, 1'b1};
        tbl[18] = '{1'b0, 32'h0,      4'h0, 1'b0, 32'h0,      4'h0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h10C,    4'h0, 32'h77,        1'b0, 1'b1, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 32'h0,      4'h0, 1'b0, 32'h0,      4'h0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h10C,    4'h0, 32'h77,        1'b0, 1'b0, 1'b0, 1'b1};

        // Reset with both requests high: grants must stay suppressed
        Rst = 1'b1;
        idle_inputs();
        P0_Din    = 32'h55;
        bram_dout = 32'h0;
        P0_Req = 1'b1; P1_Req = 1'b1;
        tick();
        tick();
        #2;
        check1("rst.g0", P0_Gnt, 1'b0);
        check1("rst.g1", P1_Gnt, 1'b0);
        check1("rst.en", O_EN, 1'b0);
        check32("rst.oaddr", O_Addr, 32'h0);
        check1("rst.busy", Busy, 1'b0);
        check1("rst.owner", Owner, 1'b0);
        check1("rst.rv0", P0_RValid, 1'b0);
        check32("rst.dout1", P1_Dout, 32'h0);
        idle_inputs();
        tick();
        Rst = 1'b0;

        // Single read, write, interleaved reads
        for (int i = 0; i < 20; i++) begin
            P0_Req = tbl[i].r0; P0_Addr = tbl[i].a0; P0_WEN = tbl[i].w0;
            P1_Req = tbl[i].r1; P1_Addr = tbl[i].a1; P1_WEN = tbl[i].w1; P1_Din = tbl[i].d1;
            #3;
            check1($sformatf("row%0d.g0", i), P0_Gnt, tbl[i].g0);
            check1($sformatf("row%0d.g1", i), P1_Gnt, tbl[i].g1);
            check1($sformatf("row%0d.en", i), O_EN, tbl[i].en);
            check32($sformatf("row%0d.oaddr", i), O_Addr, tbl[i].oaddr);
            check32($sformatf("row%0d.owen", i), {28'h0, O_WEN}, {28'h0, tbl[i].owen});
            check32($sformatf("row%0d.odin", i), O_Din, tbl[i].odin);
            check1($sformatf("row%0d.rv0", i), P0_RValid, tbl[i].rv0);
            check1($sformatf("row%0d.rv1", i), P1_RValid, tbl[i].rv1);
            check32($sformatf("row%0d.dout0", i), P0_Dout, tbl[i].rv0 ? bram_dout : 32'h0);
            check32($sformatf("row%0d.dout1", i), P1_Dout, tbl[i].rv1 ? bram_dout : 32'h0);
            check1($sformatf("row%0d.busy", i), Busy, tbl[i].busy);
            check1($sformatf("row%0d.owner", i), Owner, tbl[i].owner);
            tick();
        end

        // Fresh reset, then both sides hold Req: 8-beat bursts alternate without bubbles
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        P0_Req = 1'b1; P0_WEN = 4'hF; P0_Addr = 32'h200;
        P1_Req = 1'b1; P1_WEN = 4'hF; P1_Addr = 32'h300;
        for (int c = 1; c <= 24; c++) begin
            #3;
            check1($sformatf("burst%0d.g0", c), P0_Gnt, (((c - 1) / 8) % 2) == 0);
            check1($sformatf("burst%0d.g1", c), P1_Gnt, (((c - 1) / 8) % 2) == 1);
            tick();
        end

        // Lone requester: P1 keeps the port for 20 beats, never yielding
        idle_inputs();
        tick();
        P1_Req = 1'b1; P1_WEN = 4'hF; P1_Addr = 32'h400;
        for (int c = 1; c <= 20; c++) begin
            #3;
            check1($sformatf("lone%0d.g1", c), P1_Gnt, 1'b1);
            check1($sformatf("lone%0d.g0", c), P0_Gnt, 1'b0);
            tick();
        end
        idle_inputs();
        #3;
        check1("lone.owner", Owner, 1'b1);
        check1("lone.en", O_EN, 1'b1);
        tick();
        tick();

        // Reset one cycle after a read grant: O_EN drops at once, the tag is lost
        P0_Req = 1'b1; P0_WEN = 4'h0; P0_Addr = 32'h40;
        #3;
        check1("rstrd.g0", P0_Gnt, 1'b1);
        tick();
        idle_inputs();
        check1("rstrd.en_pre", O_EN, 1'b1);
        check32("rstrd.addr_pre", O_Addr, 32'h40);
        Rst = 1'b1;
        #1;
        check1("rstrd.en_async", O_EN, 1'b0);
        check1("rstrd.busy", Busy, 1'b0);
        tick();
        Rst = 1'b0;
        for (int c = 0; c < RL + 4; c++) begin
            #3;
            check1($sformatf("rstrd%0d.rv0", c), P0_RValid, 1'b0);
            check1($sformatf("rstrd%0d.rv1", c), P1_RValid, 1'b0);
            tick();
        end
        P0_Req = 1'b1; P1_Req = 1'b1;
        #3;
        check1("rstrd.tie_g0", P0_Gnt, 1'b1);
        check1("rstrd.tie_g1", P1_Gnt, 1'b0);
        tick();
        idle_inputs();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
